// File: rtl/ps2_host_tx_if.sv
// ----------------------------------------------------------------------------
// ps2_host_tx_if
// Host-side command handshake for the PS/2 host-to-device transmitter.
//   send    : start request (master -> slave), sampled only while idle
//   command : byte to transmit (master -> slave), captured with send
//   busy    : frame in progress (slave -> master)
//   done    : one-cycle pulse, device acknowledged the byte (slave -> master)
//   error   : one-cycle pulse, device NACK or watchdog expiry (slave -> master)
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
interface ps2_host_tx_if;
   logic       send;
   logic [7:0] command;
   logic       busy;
   logic       done;
   logic       error;

   modport master (output send, output command,
                   input  busy, input  done, input  error);

   modport slave  (input  send, input  command,
                   output busy, output done, output error);
endinterface

// File: rtl/ps2_host_tx.sv
// ----------------------------------------------------------------------------
// ps2_host_tx
// Sends one command byte from the FPGA to a PS/2 device (keyboard) over the
// shared PS2_CLK / PS2_DAT pins. Both pins are driven open-drain: an output
// enable of 1 pulls the line low, 0 releases it to the pull-up.
//
// Frame: inhibit clock >= 100 us, request-to-send (data low), release clock,
// then on every device clock falling edge present data LSB first, odd
// parity, stop (released), then sample the device ACK bit and wait for both
// lines to return high.
//
// Ports
//   Clock       system clock, rising edge
//   reset       asynchronous, active-low; clears all state
//   host        ps2_host_tx_if.slave : send / command / busy / done / error
//   ps2_clk_in  raw PS2_CLK pin (asynchronous)
//   ps2_dat_in  raw PS2_DAT pin (asynchronous)
//   ps2_clk_oe  1 = pull PS2_CLK low
//   ps2_dat_oe  1 = pull PS2_DAT low
//
// Optional build macro
//   PS2_TX_TIMEOUT_EN : adds a watchdog that aborts the frame with an error
//                       pulse TIMEOUT_CYCLES after the clock is released to
//                       the device. Without it the block waits indefinitely.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module ps2_host_tx #(
   parameter int CLOCK_FREQUENCY = 25000000,
   parameter int INHIBIT_CYCLES  = CLOCK_FREQUENCY / 10000,
   parameter int TIMEOUT_CYCLES  = CLOCK_FREQUENCY / 50
) (
   input  logic         Clock,
   input  logic         reset,
   ps2_host_tx_if.slave host,
   input  logic         ps2_clk_in,
   input  logic         ps2_dat_in,
   output logic         ps2_clk_oe,
   output logic         ps2_dat_oe
);

   localparam int CNT_W = $clog2(INHIBIT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_RTS,
      S_XFER,
      S_ACK,
      S_WAIT_IDLE
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] inhibit_cnt;
   logic [3:0]       bit_cnt;
   logic [7:0]       shreg;
   logic             parity;
   logic             nack;
   logic             busy_r;
   logic             done_r;
   logic             error_r;

   // Pin synchronizers: _p0/_p1 resynchronize, clk_p2 holds the previous
   // synced clock for falling-edge detection.
   logic clk_p0, clk_p1, clk_p2;
   logic dat_p0, dat_p1;
   logic fall;

`ifdef PS2_TX_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_cnt;
`endif

   assign host.busy  = busy_r;
   assign host.done  = done_r;
   assign host.error = error_r;

   // ---- stage p0/p1/p2: synchronize pins, delay synced clock ----
   always_ff @(posedge Clock or negedge reset) begin
      if (!reset) begin
         clk_p0 <= 1'b0;
         clk_p1 <= 1'b0;
         clk_p2 <= 1'b0;
         dat_p0 <= 1'b0;
         dat_p1 <= 1'b0;
      end else begin
         clk_p0 <= ps2_clk_in;
         clk_p1 <= clk_p0;
         clk_p2 <= clk_p1;
         dat_p0 <= ps2_dat_in;
         dat_p1 <= dat_p0;
      end
   end

   // Flops clear to 0, so no false edge is seen coming out of reset.
   assign fall = clk_p2 & ~clk_p1;

   // ---- frame sequencer: registered line drives and status ----
   always_ff @(posedge Clock or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         inhibit_cnt <= '0;
         bit_cnt     <= '0;
         shreg       <= '0;
         parity      <= 1'b0;
         nack        <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         error_r     <= 1'b0;
         ps2_clk_oe  <= 1'b0;
         ps2_dat_oe  <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
         wd_cnt      <= '0;
`endif
      end else begin
         done_r  <= 1'b0;
         error_r <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
         if (state inside {S_XFER, S_ACK, S_WAIT_IDLE})
            wd_cnt <= wd_cnt + 1'b1;
`endif
         case (state)
            S_IDLE: begin
               ps2_clk_oe <= 1'b0;
               ps2_dat_oe <= 1'b0;
               if (host.send) begin
                  state       <= S_INHIBIT;
                  busy_r      <= 1'b1;
                  ps2_clk_oe  <= 1'b1;
                  shreg       <= host.command;
                  parity      <= ~^host.command;
                  inhibit_cnt <= '0;
               end
            end
            S_INHIBIT: begin
               if (inhibit_cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
                  state       <= S_RTS;
                  ps2_dat_oe  <= 1'b1;   // start bit
                  inhibit_cnt <= '0;
               end else begin
                  inhibit_cnt <= inhibit_cnt + 1'b1;
               end
            end
            S_RTS: begin
               state      <= S_XFER;
               ps2_clk_oe <= 1'b0;      // hand the clock to the device
               bit_cnt    <= '0;
`ifdef PS2_TX_TIMEOUT_EN
               wd_cnt     <= '0;
`endif
            end
            S_XFER: begin
               if (fall) begin
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt < 4'd8) begin
                     ps2_dat_oe <= ~shreg[0];
                     shreg      <= {1'b0, shreg[7:1]};
                  end else if (bit_cnt == 4'd8) begin
                     ps2_dat_oe <= ~parity;
                  end else begin
                     ps2_dat_oe <= 1'b0;   // stop bit: release the line
                     bit_cnt    <= '0;
                     state      <= S_ACK;
                  end
               end
            end
            S_ACK: begin
               if (fall) begin
                  nack  <= dat_p1;         // device pulls data low to ACK
                  state <= S_WAIT_IDLE;
               end
            end
            S_WAIT_IDLE: begin
               if (clk_p1 && dat_p1) begin
                  state   <= S_IDLE;
                  busy_r  <= 1'b0;
                  done_r  <= ~nack;
                  error_r <= nack;
                  nack    <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
`ifdef PS2_TX_TIMEOUT_EN
         // Watchdog overrides whatever the sequencer decided this cycle,
         // so a late completion can never pulse done together with error.
         if ((state inside {S_XFER, S_ACK, S_WAIT_IDLE}) &&
             (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1))) begin
            state      <= S_IDLE;
            busy_r     <= 1'b0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            done_r     <= 1'b0;
            error_r    <= 1'b1;
            nack       <= 1'b0;
            bit_cnt    <= '0;
            wd_cnt     <= '0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
module tb_ps2_host_tx;

   localparam int CLK_FREQ = 1000000;
   localparam int INHIBIT  = CLK_FREQ / 10000;   // 100 cycles
   localparam int TIMEOUT  = 4000;
   localparam int HALF     = 40;                 // 12.5 kHz device clock

   logic Clock = 1'b0;
   logic reset = 1'b0;
   logic dev_clk_low = 1'b0;
   logic dev_dat_low = 1'b0;
   logic ps2_clk_oe, ps2_dat_oe;
   logic ps2_clk_pin, ps2_dat_pin;

   int passed = 0;
   int total  = 0;

   ps2_host_tx_if hif();

   assign ps2_clk_pin = ~(ps2_clk_oe | dev_clk_low);
   assign ps2_dat_pin = ~(ps2_dat_oe | dev_dat_low);

   ps2_host_tx #(
      .CLOCK_FREQUENCY (CLK_FREQ),
      .INHIBIT_CYCLES  (INHIBIT),
      .TIMEOUT_CYCLES  (TIMEOUT)
   ) dut (
      .Clock      (Clock),
      .reset      (reset),
      .host       (hif),
      .ps2_clk_in (ps2_clk_pin),
      .ps2_dat_in (ps2_dat_pin),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_dat_oe (ps2_dat_oe)
   );

   always #5 Clock = ~Clock;

   initial begin
      #2000000;
      $display("FAIL global_timeout: observed no finish, required finish");
      $fatal(1, "bench time limit");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
   endtask

   task automatic send_cmd(input logic [7:0] c);
      @(negedge Clock);
      hif.send    = 1'b1;
      hif.command = c;
      @(negedge Clock);
      hif.send    = 1'b0;
      hif.command = 8'hA5;   // later changes must not leak into the frame
   endtask

   // Counts cycles with clk_oe high (first one already seen by caller).
   task automatic wait_xfer(output int n, output bit seen);
      n = 1;
      seen = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge Clock);
         if (ps2_clk_oe) n++;
         else if (ps2_dat_oe) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   task automatic do_frame(input logic [7:0] cmd, input bit ack_ok,
                           input int inject_at, input int reset_at, input string tag);
      logic [10:0] bits;
      logic [10:0] exp_bits;
      int  n;
      bit  seen;
      bits = '0;
      exp_bits = {1'b1, ~^cmd, cmd, 1'b0};
      send_cmd(cmd);
      chk({tag, "_busy_rise"}, {31'd0, hif.busy}, 32'd1);
      chk({tag, "_clk_oe_rise"}, {31'd0, ps2_clk_oe}, 32'd1);
      wait_xfer(n, seen);
      chk({tag, "_xfer_seen"}, {31'd0, seen}, 32'd1);
      chk({tag, "_inhibit_len"}, n, INHIBIT + 1);
      bits[0] = ps2_dat_pin;
      repeat (HALF) @(negedge Clock);
      for (int f = 1; f <= 10; f++) begin
         dev_clk_low = 1'b1;
         if (f == reset_at) begin
            @(negedge Clock);
            reset = 1'b0;
            #1;
            chk({tag, "_rst_clk_oe"}, {31'd0, ps2_clk_oe}, 32'd0);
            chk({tag, "_rst_dat_oe"}, {31'd0, ps2_dat_oe}, 32'd0);
            chk({tag, "_rst_busy"}, {31'd0, hif.busy}, 32'd0);
            dev_clk_low = 1'b0;
            return;
         end
         if (f == inject_at) begin
            hif.send    = 1'b1;
            hif.command = 8'h55;
            @(negedge Clock);
            hif.send    = 1'b0;
            hif.command = 8'h00;
            repeat (HALF - 1) @(negedge Clock);
         end else begin
            repeat (HALF) @(negedge Clock);
         end
         dev_clk_low = 1'b0;
         bits[f] = ps2_dat_pin;
         repeat (HALF) @(negedge Clock);
      end
      chk({tag, "_line_bits"}, {21'd0, bits}, {21'd0, exp_bits});
      // ACK bit from the device
      repeat (HALF / 2) @(negedge Clock);
      dev_dat_low = ack_ok;
      repeat (HALF / 2) @(negedge Clock);
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge Clock);
      dev_clk_low = 1'b0;
      dev_dat_low = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge Clock);
         if (hif.done || hif.error) begin
            seen = 1'b1;
            break;
         end
      end
      chk({tag, "_end_seen"}, {31'd0, seen}, 32'd1);
      chk({tag, "_done"}, {31'd0, hif.done}, {31'd0, ack_ok});
      chk({tag, "_error"}, {31'd0, hif.error}, {31'd0, ~ack_ok});
      chk({tag, "_busy_fall"}, {31'd0, hif.busy}, 32'd0);
      @(negedge Clock);
      chk({tag, "_pulse_1cyc"}, {30'd0, hif.done, hif.error}, 32'd0);
   endtask

   initial begin
      int  n;
      bit  seen;
      bit  bad;
      hif.send    = 1'b0;
      hif.command = 8'h00;

      // Reset state
      #1;
      chk("reset_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
      chk("reset_dat_oe", {31'd0, ps2_dat_oe}, 32'd0);
      chk("reset_busy", {31'd0, hif.busy}, 32'd0);
      chk("reset_done_err", {30'd0, hif.done, hif.error}, 32'd0);
      repeat (3) @(negedge Clock);
      reset = 1'b1;
      repeat (3) @(negedge Clock);

      // Normal frames, parity 1,1,1,0
      do_frame(8'hED, 1'b1, 0, 0, "ed");
      do_frame(8'hFF, 1'b1, 0, 0, "ff");
      do_frame(8'h00, 1'b1, 0, 0, "x00");
      do_frame(8'h01, 1'b1, 0, 0, "x01");

      // Device NACK
      do_frame(8'hED, 1'b0, 0, 0, "nack");

      // send 0x55 mid-frame must be ignored
      do_frame(8'hED, 1'b1, 4, 0, "inject");

      // Reset at fall 6, then a normal 0xF4 frame
      do_frame(8'hED, 1'b1, 0, 6, "midrst");
      bad = 1'b0;
      repeat (4) begin
         @(negedge Clock);
         if (hif.done || hif.error || hif.busy) bad = 1'b1;
      end
      reset = 1'b1;
      repeat (4) begin
         @(negedge Clock);
         if (hif.done || hif.error || hif.busy) bad = 1'b1;
      end
      chk("midrst_quiet", {31'd0, bad}, 32'd0);
      do_frame(8'hF4, 1'b1, 0, 0, "f4");

      // Device never clocks
      send_cmd(8'h00);
      wait_xfer(n, seen);
      chk("stall_xfer_seen", {31'd0, seen}, 32'd1);
`ifdef PS2_TX_TIMEOUT_EN
      n = 0;
      seen = 1'b0;
      for (int i = 1; i <= TIMEOUT + 100; i++) begin
         @(negedge Clock);
         if (hif.error || hif.done) begin
            n = i;
            seen = 1'b1;
            break;
         end
      end
      chk("to_error_seen", {31'd0, seen}, 32'd1);
      chk("to_latency", n, TIMEOUT);
      chk("to_error", {31'd0, hif.error}, 32'd1);
      chk("to_done", {31'd0, hif.done}, 32'd0);
      chk("to_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
      chk("to_busy", {31'd0, hif.busy}, 32'd0);
`else
      bad = 1'b0;
      repeat (TIMEOUT + 200) begin
         @(negedge Clock);
         if (hif.error || hif.done) bad = 1'b1;
      end
      chk("stall_no_pulse", {31'd0, bad}, 32'd0);
      chk("stall_busy", {31'd0, hif.busy}, 32'd1);
      chk("stall_dat_oe", {31'd0, ps2_dat_oe}, 32'd1);
      reset = 1'b0;
      @(negedge Clock);
      reset = 1'b1;
      @(negedge Clock);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
